// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Summary  : stopwatch control FSM with lap buffer, lap recall and long-press clear
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl #(
  parameter int LAP_DEPTH   = 8,
  parameter int LAP_AW      = 3,
  parameter bit WRAP        = 1'b1,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_start,
  input  logic              btn_lap,
  input  logic              btn_reset,
  input  logic              btn_clear,
  input  logic              lcd_busy,
  input  logic              reg_busy,
  output logic [3:0]        state,
  output logic              count_en,
  output logic              count_clr,
  output logic              lap_wr,
  output logic [LAP_AW-1:0] lap_addr,
  output logic [LAP_AW:0]   lap_count,
  output logic              lcd_req
);

  localparam int                  c_HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_CYCLES);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
  localparam logic [LAP_AW:0]     c_FULL     = (LAP_AW + 1)'(LAP_DEPTH);
  localparam logic [LAP_AW:0]     c_CNT_ONE  = (LAP_AW + 1)'(1);
  localparam logic [LAP_AW-1:0]   c_PTR_ONE  = LAP_AW'(1);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_START_WAIT  = 4'd1,
    S_RUN         = 4'd2,
    S_PAUSE_WAIT  = 4'd3,
    S_PAUSE       = 4'd4,
    S_LAP_WAIT    = 4'd5,
    S_LAP_SAVE    = 4'd6,
    S_RESET_WAIT  = 4'd7,
    S_RESET       = 4'd8,
    S_CLEAR_WAIT  = 4'd9,
    S_CLEAR       = 4'd10,
    S_RECALL_WAIT = 4'd11
  } state_t;

  state_t              r_state;
  logic [LAP_AW-1:0]   r_wr_ptr;
  logic [LAP_AW-1:0]   r_rd_ptr;
  logic [LAP_AW-1:0]   r_save_addr;
  logic [LAP_AW:0]     r_lap_count;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_hold_flag;
  logic                r_first;
  logic                r_discard;
  logic                r_step;
  logic                r_lap_wr;
  logic                r_lcd_req;

  logic                w_full;
  logic                w_save_ok;
  logic [LAP_AW-1:0]   w_newest;
  logic [LAP_AW-1:0]   w_oldest;
  logic [LAP_AW-1:0]   w_rd_prev;
  logic                w_enter_clear;

  assign w_full    = (r_lap_count == c_FULL);
  assign w_save_ok = !w_full || WRAP;
  assign w_newest  = r_wr_ptr - c_PTR_ONE;
  // Oldest valid slot; when full the low bits of the count are zero, so it lands on wr_ptr.
  assign w_oldest  = r_wr_ptr - r_lap_count[LAP_AW-1:0];
  assign w_rd_prev = (r_rd_ptr == w_oldest) ? w_newest : (r_rd_ptr - c_PTR_ONE);

  assign w_enter_clear = ((r_state == S_CLEAR_WAIT) && !btn_clear) ||
                         ((r_state == S_RESET_WAIT) && !btn_reset && r_hold_flag);

  assign state     = r_state;
  assign count_en  = (r_state == S_RUN) || (r_state == S_LAP_WAIT) || (r_state == S_LAP_SAVE);
  assign count_clr = (r_state == S_RESET);
  assign lap_addr  = (r_state == S_LAP_SAVE) ? r_save_addr : r_rd_ptr;
  assign lap_wr    = r_lap_wr;
  assign lap_count = r_lap_count;
  assign lcd_req   = r_lcd_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RESET;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_save_addr <= '0;
      r_lap_count <= '0;
      r_hold_cnt  <= '0;
      r_hold_flag <= 1'b0;
      r_first     <= 1'b0;
      r_discard   <= 1'b0;
      r_step      <= 1'b0;
      r_lap_wr    <= 1'b0;
      r_lcd_req   <= 1'b0;
    end else begin
      r_lap_wr  <= 1'b0;
      r_lcd_req <= 1'b0;
      r_step    <= 1'b0;

      // A recall shows the current slot first, then steps back to the next older lap.
      if (r_step) begin
        r_rd_ptr <= w_rd_prev;
      end

      case (r_state)
        S_IDLE: begin
          if (btn_clear) begin
            r_state <= S_CLEAR_WAIT;
          end else if (btn_start) begin
            r_state <= S_START_WAIT;
          end
        end
        S_START_WAIT: begin
          if (!btn_start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (btn_lap) begin
            r_state <= S_LAP_WAIT;
          end else if (btn_start) begin
            r_state <= S_PAUSE_WAIT;
          end
        end
        S_PAUSE_WAIT: begin
          if (!btn_start) begin
            r_state  <= S_PAUSE;
            r_rd_ptr <= w_newest;
          end
        end
        S_PAUSE: begin
          if (btn_reset) begin
            r_state <= S_RESET_WAIT;
          end else if (btn_start) begin
            r_state <= S_START_WAIT;
          end else if (btn_lap) begin
            r_state <= S_RECALL_WAIT;
          end
        end
        S_LAP_WAIT: begin
          if (!btn_lap) begin
            r_state     <= S_LAP_SAVE;
            r_first     <= 1'b1;
            r_save_addr <= r_wr_ptr;
            r_discard   <= !w_save_ok;
            if (w_save_ok) begin
              r_lap_wr  <= 1'b1;
              r_lcd_req <= 1'b1;
              r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
              if (!w_full) begin
                r_lap_count <= r_lap_count + c_CNT_ONE;
              end
            end
          end
        end
        S_LAP_SAVE: begin
          r_first <= 1'b0;
          if (r_first) begin
            if (r_discard) begin
              r_state <= S_RUN;
            end
          end else if (!lcd_busy) begin
            r_state <= S_RUN;
          end
        end
        S_RECALL_WAIT: begin
          if (!btn_lap) begin
            r_state <= S_PAUSE;
            if (r_lap_count != '0) begin
              r_lcd_req <= 1'b1;
              r_step    <= 1'b1;
            end
          end
        end
        S_RESET_WAIT: begin
          if (btn_reset) begin
            if (r_hold_cnt != c_HOLD_MAX) begin
              r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
            end
            if (r_hold_cnt == c_HOLD_MAX - c_HOLD_ONE) begin
              r_hold_flag <= 1'b1;
            end
          end else begin
            r_hold_cnt  <= '0;
            r_hold_flag <= 1'b0;
            if (!r_hold_flag) begin
              r_state <= S_RESET;
            end
          end
        end
        S_CLEAR_WAIT: begin
          // Entry into CLEAR is handled below, shared with the long-press path.
        end
        S_CLEAR: begin
          r_first <= 1'b0;
          if (!r_first && !lcd_busy) begin
            r_state <= S_RESET;
          end
        end
        S_RESET: begin
          if (!reg_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_RESET;
        end
      endcase

      if (w_enter_clear) begin
        r_state     <= S_CLEAR;
        r_first     <= 1'b1;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_lap_count <= '0;
        r_lcd_req   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// Bench for stopwatch_ctrl: a directed vector table, hand-written corner sequences and
// random stimulus, all checked against a lap-queue reference model for two configurations.
module tb_stopwatch_ctrl;

  localparam int D    = 4;
  localparam int HOLD = 4;

  logic clock = 1'b0;
  logic reset, btn_start, btn_lap, btn_reset, btn_clear, lcd_busy, reg_busy;

  logic [3:0] a_state, b_state;
  logic       a_count_en, b_count_en, a_count_clr, b_count_clr;
  logic       a_lap_wr, b_lap_wr, a_lcd_req, b_lcd_req;
  logic [1:0] a_lap_addr, b_lap_addr;
  logic [2:0] a_lap_count, b_lap_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  stopwatch_ctrl #(.LAP_DEPTH(D), .LAP_AW(2), .WRAP(1'b0), .HOLD_CYCLES(HOLD)) dut_a (
    .clock(clock), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_reset(btn_reset), .btn_clear(btn_clear), .lcd_busy(lcd_busy), .reg_busy(reg_busy),
    .state(a_state), .count_en(a_count_en), .count_clr(a_count_clr), .lap_wr(a_lap_wr),
    .lap_addr(a_lap_addr), .lap_count(a_lap_count), .lcd_req(a_lcd_req));

  stopwatch_ctrl #(.LAP_DEPTH(D), .LAP_AW(2), .WRAP(1'b1), .HOLD_CYCLES(HOLD)) dut_b (
    .clock(clock), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_reset(btn_reset), .btn_clear(btn_clear), .lcd_busy(lcd_busy), .reg_busy(reg_busy),
    .state(b_state), .count_en(b_count_en), .count_clr(b_count_clr), .lap_wr(b_lap_wr),
    .lap_addr(b_lap_addr), .lap_count(b_lap_count), .lcd_req(b_lcd_req));

  // Reference model: laps kept as an ordered list of slot numbers (oldest first).
  int m_st[2], m_n[2], m_ws[2], m_rd[2], m_sa[2], m_held[2];
  int m_slots[2][D];
  bit m_fresh[2], m_disc[2], m_step[2], m_wr[2], m_req[2];

  function automatic int older(input int k);
    for (int p = 0; p < m_n[k]; p++) begin
      if (m_slots[k][p] == m_rd[k]) return (p == 0) ? m_slots[k][m_n[k]-1] : m_slots[k][p-1];
    end
    return (m_rd[k] + D - 1) % D;
  endfunction

  function automatic void add_lap(input int k);
    if (m_n[k] == D) begin
      for (int p = 0; p < D - 1; p++) m_slots[k][p] = m_slots[k][p+1];
      m_n[k] = D - 1;
    end
    m_slots[k][m_n[k]] = m_ws[k];
    m_n[k] = m_n[k] + 1;
    m_ws[k] = (m_ws[k] + 1) % D;
  endfunction

  function automatic void do_clear(input int k);
    m_st[k] = 10; m_fresh[k] = 1'b1; m_n[k] = 0; m_ws[k] = 0; m_rd[k] = 0; m_req[k] = 1'b1;
  endfunction

  function automatic void model_step(input int k, input bit wrap);
    m_wr[k] = 1'b0;
    m_req[k] = 1'b0;
    if (reset) begin
      m_st[k] = 8; m_n[k] = 0; m_ws[k] = 0; m_rd[k] = 0; m_sa[k] = 0; m_held[k] = 0;
      m_fresh[k] = 1'b0; m_disc[k] = 1'b0; m_step[k] = 1'b0;
      return;
    end
    if (m_step[k]) begin
      m_rd[k] = older(k);
      m_step[k] = 1'b0;
    end
    case (m_st[k])
      0: if (btn_clear) m_st[k] = 9; else if (btn_start) m_st[k] = 1;
      1: if (!btn_start) m_st[k] = 2;
      2: if (btn_lap) m_st[k] = 5; else if (btn_start) m_st[k] = 3;
      3: if (!btn_start) begin m_st[k] = 4; m_rd[k] = (m_ws[k] + D - 1) % D; end
      4: if (btn_reset) m_st[k] = 7; else if (btn_start) m_st[k] = 1; else if (btn_lap) m_st[k] = 11;
      5: if (!btn_lap) begin
           m_st[k] = 6; m_fresh[k] = 1'b1; m_sa[k] = m_ws[k];
           m_disc[k] = (m_n[k] == D) && !wrap;
           if (!m_disc[k]) begin add_lap(k); m_wr[k] = 1'b1; m_req[k] = 1'b1; end
         end
      6: if (m_fresh[k]) begin m_fresh[k] = 1'b0; if (m_disc[k]) m_st[k] = 2; end
         else if (!lcd_busy) m_st[k] = 2;
      7: if (btn_reset) m_held[k] = m_held[k] + 1;
         else begin
           if (m_held[k] >= HOLD) do_clear(k); else m_st[k] = 8;
           m_held[k] = 0;
         end
      8: if (!reg_busy) m_st[k] = 0;
      9: if (!btn_clear) do_clear(k);
      10: if (m_fresh[k]) m_fresh[k] = 1'b0; else if (!lcd_busy) m_st[k] = 8;
      11: if (!btn_lap) begin
            m_st[k] = 4;
            if (m_n[k] > 0) begin m_req[k] = 1'b1; m_step[k] = 1'b1; end
          end
      default: m_st[k] = 8;
    endcase
  endfunction

  task automatic check_model(input int k);
    logic [3:0] s; logic en, clr, wr, rq; logic [1:0] ad; logic [2:0] ct;
    logic [3:0] es; logic een, eclr; logic [1:0] ead; logic [2:0] ect;
    int eai;
    if (k == 0) begin
      s = a_state; en = a_count_en; clr = a_count_clr; wr = a_lap_wr; ad = a_lap_addr; ct = a_lap_count; rq = a_lcd_req;
    end else begin
      s = b_state; en = b_count_en; clr = b_count_clr; wr = b_lap_wr; ad = b_lap_addr; ct = b_lap_count; rq = b_lcd_req;
    end
    es   = m_st[k][3:0];
    een  = (m_st[k] == 2) || (m_st[k] == 5) || (m_st[k] == 6);
    eclr = (m_st[k] == 8);
    eai  = (m_st[k] == 6) ? m_sa[k] : m_rd[k];
    ead  = eai[1:0];
    ect  = m_n[k][2:0];
    checks++;
    if (s !== es || en !== een || clr !== eclr || wr !== m_wr[k] || ad !== ead || ct !== ect || rq !== m_req[k]) begin
      errors++;
      $display("FAIL model dut%0d cyc=%0d: got st=%0d en=%b clr=%b wr=%b addr=%0d cnt=%0d req=%b; want st=%0d en=%b clr=%b wr=%b addr=%0d cnt=%0d req=%b",
               k, cyc, s, en, clr, wr, ad, ct, rq, es, een, eclr, m_wr[k], ead, ect, m_req[k]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    check_model(0);
    check_model(1);
    cyc++;
  endtask

  task automatic drive(input logic [6:0] v);
    {reset, btn_start, btn_lap, btn_reset, btn_clear, lcd_busy, reg_busy} = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0] in;
    logic [3:0] st;
    logic       en, clr, wr;
    logic [1:0] ad;
    logic [2:0] ct;
    logic       rq;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic [6:0] in, input int st, input logic en, input logic clr,
                      input logic wr, input int ad, input int ct, input logic rq);
    vec_t v;
    v.in = in; v.st = st[3:0]; v.en = en; v.clr = clr; v.wr = wr;
    v.ad = ad[1:0]; v.ct = ct[2:0]; v.rq = rq;
    vecs.push_back(v);
  endtask

  initial begin
    drive(7'b0000000);

    // Inputs order: reset start lap reset_btn clear lcd_busy reg_busy (DUT with WRAP=0).
    addv(7'b1000001, 8, 0, 1, 0, 0, 0, 0);
    addv(7'b0000000, 0, 0, 0, 0, 0, 0, 0);
    addv(7'b0100000, 1, 0, 0, 0, 0, 0, 0);
    addv(7'b0100000, 1, 0, 0, 0, 0, 0, 0);
    addv(7'b0100000, 1, 0, 0, 0, 0, 0, 0);
    addv(7'b0000000, 2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      addv(7'b0010000, 5, 1, 0, 0, 0, i, 0);
      addv(7'b0000000, 6, 1, 0, 1, i, i + 1, 1);
      addv(7'b0000000, 6, 1, 0, 0, i, i + 1, 0);
      addv(7'b0000000, 2, 1, 0, 0, 0, i + 1, 0);
    end
    addv(7'b0010000, 5, 1, 0, 0, 0, 4, 0);
    addv(7'b0000000, 6, 1, 0, 0, 0, 4, 0);
    addv(7'b0000010, 2, 1, 0, 0, 0, 4, 0);
    addv(7'b0100000, 3, 0, 0, 0, 0, 4, 0);
    addv(7'b0000000, 4, 0, 0, 0, 3, 4, 0);
    addv(7'b0010000, 11, 0, 0, 0, 3, 4, 0);
    addv(7'b0000000, 4, 0, 0, 0, 3, 4, 1);
    addv(7'b0000000, 4, 0, 0, 0, 2, 4, 0);
    addv(7'b0001000, 7, 0, 0, 0, 2, 4, 0);
    addv(7'b0001000, 7, 0, 0, 0, 2, 4, 0);
    addv(7'b0001000, 7, 0, 0, 0, 2, 4, 0);
    addv(7'b0000001, 8, 0, 1, 0, 2, 4, 0);
    addv(7'b0000001, 8, 0, 1, 0, 2, 4, 0);
    addv(7'b0000000, 0, 0, 0, 0, 2, 4, 0);
    addv(7'b0100100, 9, 0, 0, 0, 2, 4, 0);
    addv(7'b0000100, 9, 0, 0, 0, 2, 4, 0);
    addv(7'b0000010, 10, 0, 0, 0, 0, 0, 1);
    addv(7'b0000010, 10, 0, 0, 0, 0, 0, 0);
    addv(7'b0000010, 10, 0, 0, 0, 0, 0, 0);
    addv(7'b0000000, 8, 0, 1, 0, 0, 0, 0);
    addv(7'b0000000, 0, 0, 0, 0, 0, 0, 0);
    addv(7'b0010000, 0, 0, 0, 0, 0, 0, 0);
    addv(7'b0001000, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      tick();
      checks++;
      if (a_state !== vecs[i].st || a_count_en !== vecs[i].en || a_count_clr !== vecs[i].clr ||
          a_lap_wr !== vecs[i].wr || a_lap_addr !== vecs[i].ad || a_lap_count !== vecs[i].ct ||
          a_lcd_req !== vecs[i].rq) begin
        errors++;
        $display("FAIL tbl row=%0d: got st=%0d en=%b clr=%b wr=%b addr=%0d cnt=%0d req=%b; want st=%0d en=%b clr=%b wr=%b addr=%0d cnt=%0d req=%b",
                 i, a_state, a_count_en, a_count_clr, a_lap_wr, a_lap_addr, a_lap_count, a_lcd_req,
                 vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].wr, vecs[i].ad, vecs[i].ct, vecs[i].rq);
      end
    end

    // Wrap policy: five laps, then three recalls, then a long-press clear.
    drive(7'b1000000); tick();
    drive(7'b0000000); tick();
    chk("idle_after_reset", b_state, 0);
    drive(7'b0100000); tick();
    drive(7'b0000000); tick();
    chk("run_b", b_state, 2);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] wa [5];
      logic [2:0] wc [5];
      wa = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      wc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      drive(7'b0010000); tick();
      drive(7'b0000000); tick();
      chk("wrap_lap_wr", b_lap_wr, 1);
      chk("wrap_lap_addr", b_lap_addr, wa[i]);
      chk("wrap_lap_count", b_lap_count, wc[i]);
      if (i == 4) begin
        chk("discard_no_wr", a_lap_wr, 0);
        chk("discard_no_req", a_lcd_req, 0);
      end
      tick(); tick();
    end
    drive(7'b0100000); tick();
    drive(7'b0000000); tick();
    chk("pause_b", b_state, 4);
    for (int i = 0; i < 3; i++) begin
      logic [1:0] ra [3];
      ra = '{2'd0, 2'd3, 2'd2};
      drive(7'b0010000); tick();
      drive(7'b0000000); tick();
      chk("recall_req", b_lcd_req, 1);
      chk("recall_addr", b_lap_addr, ra[i]);
      tick();
    end
    drive(7'b0001000);
    for (int i = 0; i < 6; i++) tick();
    drive(7'b0000000); tick();
    chk("long_press_clear_state", b_state, 10);
    chk("long_press_clear_req", b_lcd_req, 1);
    chk("long_press_clear_count", b_lap_count, 0);
    tick();
    tick();
    chk("clear_to_reset", b_state, 8);
    tick();
    chk("reset_to_idle", b_state, 0);

    // Short press of reset keeps laps.
    drive(7'b0100000); tick();
    drive(7'b0000000); tick();
    drive(7'b0010000); tick();
    drive(7'b0000000); tick(); tick(); tick();
    drive(7'b0100000); tick();
    drive(7'b0000000); tick();
    drive(7'b0001000); tick(); tick(); tick();
    drive(7'b0000000); tick();
    chk("short_press_reset", b_state, 8);
    chk("short_press_count", b_lap_count, 1);
    tick();

    // LCD busy stretches LAP_SAVE; reset mid-save aborts it.
    drive(7'b0100000); tick();
    drive(7'b0000000); tick();
    drive(7'b0010000); tick();
    drive(7'b0000010); tick();
    chk("busy_lap_wr", b_lap_wr, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_hold_state", b_state, 6);
      chk("busy_count_en", b_count_en, 1);
    end
    drive(7'b0000000); tick();
    chk("busy_release_run", b_state, 2);
    drive(7'b0010000); tick();
    drive(7'b0000010); tick();
    chk("abort_first_wr", b_lap_wr, 1);
    tick();
    drive(7'b1000010); tick();
    chk("abort_state", b_state, 8);
    chk("abort_no_wr", b_lap_wr, 0);
    chk("abort_count", b_lap_count, 0);
    drive(7'b0000001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_more_wr", b_lap_wr, 0);
      chk("abort_no_more_req", b_lcd_req, 0);
    end

    // Random stimulus against the model.
    drive(7'b0000000);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 3) == 0) btn_lap = ~btn_lap;
      if ($urandom_range(0, 7) == 0) btn_reset = ~btn_reset;
      if ($urandom_range(0, 9) == 0) btn_clear = ~btn_clear;
      lcd_busy = ($urandom_range(0, 2) == 0);
      reg_busy = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised stopwatch control FSM with lap memory management. It sits between the debounced push-buttons and the datapath: the time counter, the lap register file and the LCD writer. It sequences start, pause, lap, reset and clear, and adds three things to the original control flow: a configurable-depth lap buffer with a wrap or discard policy, lap recall while paused, and a long-press reset that also clears the lap memory.

## Interface
- LAP_DEPTH, 8: number of lap slots; power of two, ≥2.
- LAP_AW, 3: log2(LAP_DEPTH).
- WRAP, 1: 1 = overwrite oldest lap when full; 0 = discard new laps when full.
- HOLD_CYCLES, 50_000_000: cycles btn_reset must be held to escalate to clear; ≥2.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high block reset.
- btn_start  in  1  start/pause button, debounced level, active-high.
- btn_lap  in  1  lap/recall button, debounced level.
- btn_reset  in  1  stopwatch reset button, debounced level.
- btn_clear  in  1  clear button, debounced level.
- lcd_busy  in  1  LCD writer busy.
- reg_busy  in  1  time-counter clear in progress.
- state  out  4  current state code.
- count_en  out  1  time counter enable.
- count_clr  out  1  time counter clear.
- lap_wr  out  1  one-cycle lap-register write strobe.
- lap_addr  out  LAP_AW  lap slot written (valid with lap_wr) or recalled.
- lap_count  out  LAP_AW+1  number of valid laps, saturates at LAP_DEPTH.
- lcd_req  out  1  one-cycle LCD refresh request.

## Operation
- State codes: IDLE=0, START_WAIT=1, RUN=2, PAUSE_WAIT=3, PAUSE=4, LAP_WAIT=5, LAP_SAVE=6, RESET_WAIT=7, RESET=8, CLEAR_WAIT=9, CLEAR=10, RECALL_WAIT=11. Codes 12–15 go to RESET.
- All *_WAIT states hold until their button is released (level 0), then advance. Each press therefore yields exactly one action.
- IDLE: btn_clear → CLEAR_WAIT; else btn_start → START_WAIT; else stay.
- START_WAIT → RUN on release.
- RUN: btn_lap → LAP_WAIT; else btn_start → PAUSE_WAIT; else stay.
- PAUSE_WAIT → PAUSE on release.
- LAP_WAIT → LAP_SAVE on release.
- LAP_SAVE, first cycle:
  - If not full, or WRAP=1: lap_wr=1, lap_addr=wr_ptr, wr_ptr+1 mod LAP_DEPTH, lap_count+1 saturating, lcd_req=1.
  - If full and WRAP=0: no write and no lcd_req; go to RUN next cycle.
  - From the second cycle on: exit to RUN when lcd_busy=0.
- PAUSE: btn_reset → RESET_WAIT; else btn_start → START_WAIT; else btn_lap → RECALL_WAIT; else stay.
- RECALL_WAIT, on release:
  - If lap_count>0: rd_ptr−1 mod LAP_DEPTH, restricted to the valid laps (wraps from the oldest back to the newest); lcd_req=1 for one cycle; return to PAUSE.
  - If lap_count=0: return to PAUSE with no request.
- On every entry to PAUSE from PAUSE_WAIT, rd_ptr is set to the newest lap (wr_ptr−1).
- lap_addr = wr_ptr during LAP_SAVE; otherwise rd_ptr.
- RESET_WAIT: hold counter increments while btn_reset=1; hold_flag sets when the counter reaches HOLD_CYCLES. On release → CLEAR if hold_flag, else RESET. The counter and flag clear on exit.
- CLEAR_WAIT → CLEAR on release.
- CLEAR, first cycle: wr_ptr=0, rd_ptr=0, lap_count=0, lcd_req=1. From the second cycle on: exit to RESET when lcd_busy=0.
- RESET: exit to IDLE when reg_busy=0; minimum one cycle.
- count_en=1 in RUN, LAP_WAIT and LAP_SAVE only. Pause stops counting at the press, not the release.
- count_clr=1 in RESET only.

## Timing
- Next state is registered. All inputs are sampled at the rising edge and take effect on the state one cycle later.
- state, count_en and count_clr are decoded from the state register (no extra latency). lap_wr and lcd_req are registered one-cycle pulses in the first cycle of LAP_SAVE, CLEAR, or the cycle after a RECALL_WAIT release.
- Reset (synchronous, clocked in while reset=1) gives:
  - state=RESET(8), count_clr=1;
  - count_en, lap_wr, lcd_req = 0;
  - lap_count=0, lap_addr=0, pointers and hold counter cleared.
- Reset mid-LAP_SAVE or mid-CLEAR aborts the operation; no further strobes are issued.
- Simultaneous presses follow the per-state priority above; buttons not listed for the current state are ignored.
- Minimum cycles:
  - lap press-to-write: 1 cycle after release;
  - RUN→PAUSE: count_en falls 1 cycle after the btn_start press is sampled.

## Test plan
- Reset then reg_busy=0: state 8 for 1 cycle with count_clr=1, then IDLE(0). btn_start pulse (3 cycles) → START_WAIT for 3 cycles, RUN on release, count_en=1.
- LAP_DEPTH=4, WRAP=0: 5 laps in RUN with lcd_busy low → lap_wr at addresses 0, 1, 2, 3; fifth lap produces no lap_wr and no lcd_req; lap_count=4.
- WRAP=1, same stimulus → fifth write at lap_addr=0, lap_count stays 4. Then pause and issue 3 recall presses → lap_addr 0, 3, 2, each with one lcd_req.
- HOLD_CYCLES=4 in PAUSE:
  - btn_reset held 3 cycles → RESET only, lap_count unchanged;
  - held 6 cycles → CLEAR (lcd_req, lap_count=0) → RESET → IDLE.
- lcd_busy high for 5 cycles after the lap strobe → LAP_SAVE lasts until lcd_busy falls, count_en stays 1 throughout. Assert reset mid-LAP_SAVE → state 8 next cycle, no second lap_wr.
- In IDLE with btn_clear and btn_start both asserted → CLEAR_WAIT (clear has priority). btn_lap in IDLE → no state change.
